// File: rtl/serial_right_shifter.sv
// serial_right_shifter
// Multi-cycle right shifter for the ALU datapath (SRL/SRA/SRLV/SRAV).
// A working register is shifted right by up to STEP bits per clock. The
// vacated MSBs take a fill bit that is frozen when the operation is accepted.
// busy is high while shifting; done pulses for one cycle when out is updated.
// out is only ever written with a final result, so the pipeline never sees a
// partially shifted value.

module serial_right_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   in,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               arith,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

   state_t               r_state;
   logic [WIDTH-1:0]     r_work;
   logic [SHAMT_W-1:0]   r_count;
   logic                 r_fill;
   logic                 r_busy;
   logic                 r_done;
   logic [WIDTH-1:0]     r_out;

   logic [SHAMT_W-1:0]   w_k;
   logic [SHAMT_W-1:0]   w_countNext;
   logic [WIDTH-1:0]     w_fillMask;
   logic [WIDTH-1:0]     w_shifted;

   // One shift step: move by min(STEP, remaining) and fill the vacated MSBs.
   // The mask of vacated positions is the complement of an all-ones word
   // shifted by the same amount.
   always_comb begin
      w_k         = (r_count < STEP_AMT) ? r_count : STEP_AMT;
      w_countNext = r_count - w_k;
      w_fillMask  = ~({WIDTH{1'b1}} >> w_k);
      w_shifted   = (r_work >> w_k) | (r_fill ? w_fillMask : {WIDTH{1'b0}});
   end

   // Control FSM with registered busy/done and the result register. A start
   // is accepted from IDLE or DONE (back-to-back); in SHIFT it is ignored so
   // the captured operands stay intact.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_work  <= '0;
         r_count <= '0;
         r_fill  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_out   <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_work  <= in;
                  r_count <= shamt;
                  r_fill  <= arith & in[WIDTH-1];
                  if (shamt == '0) begin
                     r_out   <= in;
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= SHIFT;
                     r_busy  <= 1'b1;
                     r_done  <= 1'b0;
                  end
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
               end
            end
            SHIFT: begin
               r_work  <= w_shifted;
               r_count <= w_countNext;
               if (w_countNext == '0) begin
                  r_out   <= w_shifted;
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign out  = r_out;

endmodule

// File: tb/tb_serial_right_shifter.sv
// Testbench for serial_right_shifter.
// Two instances (STEP=1 and STEP=4) share the same inputs. Expected results
// come from plain >> / >>> arithmetic, and completion edges from
// ceil(shamt/STEP).

module tb_serial_right_shifter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] in;
   logic [4:0]  shamt;
   logic        arith;

   logic        busy1, done1;
   logic [31:0] out1;
   logic        busy4, done4;
   logic [31:0] out4;

   int checks = 0;
   int passed = 0;

   logic [31:0] held1;
   logic [31:0] held4;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   serial_right_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .in(in), .shamt(shamt),
      .arith(arith), .busy(busy1), .done(done1), .out(out1)
   );

   serial_right_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .in(in), .shamt(shamt),
      .arith(arith), .busy(busy4), .done(done4), .out(out4)
   );

   // Reference result: logical or arithmetic right shift.
   function automatic logic [31:0] refShift(input logic [31:0] a, input int s, input logic ar);
      logic signed [31:0] sa;
      sa = a;
      if (ar) return 32'(sa >>> s);
      return a >> s;
   endfunction

   // Number of edges after the accepting edge until done is shown.
   function automatic int doneEdge(input int s, input int step);
      return (s + step - 1) / step;
   endfunction

   // Present a start pulse so it is sampled at the next rising edge (E0);
   // returns just after E0.
   task automatic applyStimulus(input logic [31:0] a, input logic [4:0] s, input logic ar);
      start = 1'b1;
      in    = a;
      shamt = s;
      arith = ar;
      @(negedge clk);
      start = 1'b0;
      in    = $urandom;
      shamt = 5'($urandom);
      arith = 1'($urandom);
   endtask

   // Wait (bounded) until both instances are idle.
   task automatic waitIdle();
      int k;
      k = 0;
      while ((busy1 || busy4) && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) begin
         checks++;
         $display("[TB] FAIL waitIdle timeout busy1=%b busy4=%b", busy1, busy4);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start = 1'b0;
      in = 32'hDEADBEEF;
      shamt = 5'd7;
      arith = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy1 !== 1'b0) $display("[TB] FAIL reset busy1 got %b want 0", busy1); else passed++;
      checks++; if (done1 !== 1'b0) $display("[TB] FAIL reset done1 got %b want 0", done1); else passed++;
      checks++; if (out1 !== 32'h0) $display("[TB] FAIL reset out1 got %h want 0", out1); else passed++;
      checks++; if (busy4 !== 1'b0) $display("[TB] FAIL reset busy4 got %b want 0", busy4); else passed++;
      checks++; if (done4 !== 1'b0) $display("[TB] FAIL reset done4 got %b want 0", done4); else passed++;
      checks++; if (out4 !== 32'h0) $display("[TB] FAIL reset out4 got %h want 0", out4); else passed++;
      rst = 1'b1;
      @(negedge clk);
      checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) $display("[TB] FAIL idle after reset busy1=%b done1=%b want 0/0", busy1, done1); else passed++;
      held1 = 32'h0;
      held4 = 32'h0;
   endtask

   task automatic test_srl_basic();
      logic [31:0] exp;
      exp = 32'h08000000;
      waitIdle();
      applyStimulus(32'h80000000, 5'd4, 1'b0);
      for (int n = 0; n <= 5; n++) begin
         checks++; if (busy1 !== (n < 4)) $display("[TB] FAIL srl busy1 n=%0d got %b want %b", n, busy1, (n < 4)); else passed++;
         checks++; if (done1 !== (n == 4)) $display("[TB] FAIL srl done1 n=%0d got %b want %b", n, done1, (n == 4)); else passed++;
         checks++; if (out1 !== ((n >= 4) ? exp : held1)) $display("[TB] FAIL srl out1 n=%0d got %h want %h", n, out1, ((n >= 4) ? exp : held1)); else passed++;
         @(negedge clk);
      end
      held1 = exp;
      held4 = exp;
   endtask

   task automatic test_sra_full();
      logic [31:0] exp;
      int d1, d4;
      exp = refShift(32'h80000000, 31, 1'b1);
      d1 = doneEdge(31, 1);
      d4 = doneEdge(31, 4);
      waitIdle();
      applyStimulus(32'h80000000, 5'd31, 1'b1);
      for (int n = 0; n <= d1 + 1; n++) begin
         checks++; if (busy1 !== (n < d1)) $display("[TB] FAIL sra31 busy1 n=%0d got %b want %b", n, busy1, (n < d1)); else passed++;
         checks++; if (done1 !== (n == d1)) $display("[TB] FAIL sra31 done1 n=%0d got %b want %b", n, done1, (n == d1)); else passed++;
         checks++; if (out1 !== ((n >= d1) ? exp : held1)) $display("[TB] FAIL sra31 out1 n=%0d got %h want %h", n, out1, ((n >= d1) ? exp : held1)); else passed++;
         checks++; if (busy4 !== (n < d4)) $display("[TB] FAIL sra31 busy4 n=%0d got %b want %b", n, busy4, (n < d4)); else passed++;
         checks++; if (done4 !== (n == d4)) $display("[TB] FAIL sra31 done4 n=%0d got %b want %b", n, done4, (n == d4)); else passed++;
         checks++; if (out4 !== ((n >= d4) ? exp : held4)) $display("[TB] FAIL sra31 out4 n=%0d got %h want %h", n, out4, ((n >= d4) ? exp : held4)); else passed++;
         @(negedge clk);
      end
      held1 = exp;
      held4 = exp;
   endtask

   task automatic test_zero_shift();
      waitIdle();
      applyStimulus(32'h12345678, 5'd0, 1'b1);
      checks++; if (busy1 !== 1'b0 || done1 !== 1'b1) $display("[TB] FAIL zero busy1/done1 got %b/%b want 0/1", busy1, done1); else passed++;
      checks++; if (out1 !== 32'h12345678) $display("[TB] FAIL zero out1 got %h want 12345678", out1); else passed++;
      checks++; if (busy4 !== 1'b0 || done4 !== 1'b1) $display("[TB] FAIL zero busy4/done4 got %b/%b want 0/1", busy4, done4); else passed++;
      checks++; if (out4 !== 32'h12345678) $display("[TB] FAIL zero out4 got %h want 12345678", out4); else passed++;
      @(negedge clk);
      checks++; if (done1 !== 1'b0 || out1 !== 32'h12345678) $display("[TB] FAIL zero hold done1=%b out1=%h want 0/12345678", done1, out1); else passed++;
      held1 = 32'h12345678;
      held4 = 32'h12345678;
   endtask

   task automatic test_ignore_start();
      waitIdle();
      applyStimulus(32'hF0000000, 5'd8, 1'b0);
      for (int n = 0; n <= 9; n++) begin
         checks++; if (busy1 !== (n < 8)) $display("[TB] FAIL ignore busy1 n=%0d got %b want %b", n, busy1, (n < 8)); else passed++;
         checks++; if (done1 !== (n == 8)) $display("[TB] FAIL ignore done1 n=%0d got %b want %b", n, done1, (n == 8)); else passed++;
         checks++; if (out1 !== ((n >= 8) ? 32'h00F00000 : held1)) $display("[TB] FAIL ignore out1 n=%0d got %h want %h", n, out1, ((n >= 8) ? 32'h00F00000 : held1)); else passed++;
         if (n == 2) begin
            start = 1'b1;
            in    = 32'h1;
            shamt = 5'd1;
            arith = 1'b0;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      // The STEP=4 copy sat in DONE at E3 and legitimately took the new request.
      checks++; if (out4 !== refShift(32'h1, 1, 1'b0)) $display("[TB] FAIL ignore out4 got %h want %h", out4, refShift(32'h1, 1, 1'b0)); else passed++;
      held1 = 32'h00F00000;
      held4 = refShift(32'h1, 1, 1'b0);
   endtask

   task automatic test_reset_midop();
      waitIdle();
      applyStimulus(32'hA5A5A5A5, 5'd10, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) $display("[TB] FAIL rstmid busy1/done1 got %b/%b want 0/0", busy1, done1); else passed++;
      checks++; if (out1 !== 32'h0) $display("[TB] FAIL rstmid out1 got %h want 0", out1); else passed++;
      checks++; if (busy4 !== 1'b0 || out4 !== 32'h0) $display("[TB] FAIL rstmid busy4/out4 got %b/%h want 0/0", busy4, out4); else passed++;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         checks++; if (done1 !== 1'b0 || busy1 !== 1'b0 || out1 !== 32'h0) $display("[TB] FAIL rstmid after n=%0d busy1=%b done1=%b out1=%h want 0/0/0", n, busy1, done1, out1); else passed++;
      end
      held1 = 32'h0;
      held4 = 32'h0;
   endtask

   task automatic test_back_to_back();
      waitIdle();
      applyStimulus(32'hFFFFFF00, 5'd4, 1'b1);
      for (int n = 0; n < 4; n++) begin
         checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) $display("[TB] FAIL b2b first n=%0d busy1/done1 got %b/%b want 1/0", n, busy1, done1); else passed++;
         @(negedge clk);
      end
      checks++; if (done1 !== 1'b1 || out1 !== 32'hFFFFFFF0) $display("[TB] FAIL b2b first result done1=%b out1=%h want 1/fffffff0", done1, out1); else passed++;
      applyStimulus(32'h00000100, 5'd8, 1'b0);
      checks++; if (busy1 !== 1'b1 || done1 !== 1'b0 || out1 !== 32'hFFFFFFF0) $display("[TB] FAIL b2b accept busy1=%b done1=%b out1=%h want 1/0/fffffff0", busy1, done1, out1); else passed++;
      for (int n = 1; n < 8; n++) begin
         @(negedge clk);
         checks++; if (busy1 !== (n < 8 - 0 && n < 8)) $display("[TB] FAIL b2b second busy1 n=%0d got %b want 1", n, busy1); else passed++;
      end
      @(negedge clk);
      checks++; if (done1 !== 1'b1 || out1 !== 32'h00000001) $display("[TB] FAIL b2b second result done1=%b out1=%h want 1/00000001", done1, out1); else passed++;
      checks++; if (out4 !== 32'h00000001) $display("[TB] FAIL b2b out4 got %h want 00000001", out4); else passed++;
      held1 = 32'h1;
      held4 = 32'h1;
   endtask

   task automatic test_random();
      logic [31:0] a, exp;
      logic [4:0]  s;
      logic        ar;
      int d1, d4;
      for (int op = 0; op < 40; op++) begin
         a  = $urandom;
         ar = 1'($urandom);
         case ($urandom_range(0, 5))
            0:       s = 5'd0;
            1:       s = 5'd31;
            default: s = 5'($urandom);
         endcase
         exp = refShift(a, int'(s), ar);
         d1  = doneEdge(int'(s), 1);
         d4  = doneEdge(int'(s), 4);
         waitIdle();
         applyStimulus(a, s, ar);
         for (int n = 0; n <= d1 + 1; n++) begin
            checks++; if (busy1 !== (n < d1) || done1 !== (n == d1)) $display("[TB] FAIL rand%0d busy1/done1 n=%0d got %b/%b want %b/%b", op, n, busy1, done1, (n < d1), (n == d1)); else passed++;
            checks++; if (out1 !== ((n >= d1) ? exp : held1)) $display("[TB] FAIL rand%0d out1 n=%0d got %h want %h", op, n, out1, ((n >= d1) ? exp : held1)); else passed++;
            checks++; if (busy4 !== (n < d4) || done4 !== (n == d4)) $display("[TB] FAIL rand%0d busy4/done4 n=%0d got %b/%b want %b/%b", op, n, busy4, done4, (n < d4), (n == d4)); else passed++;
            checks++; if (out4 !== ((n >= d4) ? exp : held4)) $display("[TB] FAIL rand%0d out4 n=%0d got %h want %h", op, n, out4, ((n >= d4) ? exp : held4)); else passed++;
            @(negedge clk);
         end
         held1 = exp;
         held4 = exp;
      end
   endtask

   initial begin
      test_reset();
      test_srl_basic();
      test_sra_full();
      test_zero_shift();
      test_ignore_start();
      test_reset_midop();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
